ula_port: RTL

- ULA I/O port 0xFE block. Sits between the CPU I/O bus and the video/audio outputs.
- Captures CPU OUT writes to even port addresses: border colour to the video stage, MIC/beeper to audio.
- Supplies IN data for even port addresses: keyboard matrix columns plus synchronised tape EAR.
- Drives a 1-bit sigma-delta audio output from the beeper/MIC/EAR mix.

---
 rtl/ula_port.sv | 112 +++++++++++
 1 files changed

// File: rtl/ula_port.sv
// ULA I/O port 0xFE: border/MIC/beeper latch, keyboard/EAR read path
// and a first-order sigma-delta audio DAC.
module ula_port #(
    parameter logic [7:0] BEEP_LVL = 8'd160,
    parameter logic [7:0] MIC_LVL  = 8'd48,
    parameter logic [7:0] EAR_LVL  = 8'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        n_iorq,
    input  logic        n_wr,
    input  logic        n_rd,
    input  logic [4:0]  key_data,
    input  logic        ear_in,
    output logic        port_sel,
    output logic [7:0]  port_dout,
    output logic [2:0]  border,
    output logic        mic,
    output logic        beeper,
    output logic        port_wr,
    output logic        audio_pwm
);

    logic       ws;
    logic       ws_m;
    logic       ws_s;
    logic       ws_prev;
    logic [1:0] sync_ok;
    logic       accept;

    logic       ear_m;
    logic       ear_s;

    logic [9:0] level_raw;
    logic [7:0] level;
    logic [7:0] acc;
    logic [8:0] sum;

    logic       unused_addr;

    assign unused_addr = ^cpu_addr[15:1];

    assign ws = ~n_iorq & ~n_wr;

    // sync_ok keeps ws_prev high until the synchroniser has refilled,
    // so a strobe held across reset release is not seen as a new edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_m    <= 1'b0;
            ws_s    <= 1'b0;
            ws_prev <= 1'b1;
            sync_ok <= 2'b00;
        end else begin
            ws_m    <= ws;
            ws_s    <= ws_m;
            sync_ok <= {sync_ok[0], 1'b1};
            ws_prev <= sync_ok[1] ? ws_s : 1'b1;
        end
    end

    assign accept = ws_s & ~ws_prev & ~cpu_addr[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            border  <= 3'd0;
            mic     <= 1'b0;
            beeper  <= 1'b0;
            port_wr <= 1'b0;
        end else begin
            port_wr <= accept;
            if (accept) begin
                border <= cpu_dout[2:0];
                mic    <= cpu_dout[3];
                beeper <= cpu_dout[4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ear_m <= 1'b0;
            ear_s <= 1'b0;
        end else begin
            ear_m <= ear_in;
            ear_s <= ear_m;
        end
    end

    assign port_sel  = ~n_iorq & ~n_rd & ~cpu_addr[0];
    assign port_dout = {1'b1, ear_s, 1'b1, key_data};

    always_comb begin
        level_raw = ({2'b00, BEEP_LVL} & {10{beeper}})
                  + ({2'b00, MIC_LVL}  & {10{mic}})
                  + ({2'b00, EAR_LVL}  & {10{ear_s}});
        level     = (|level_raw[9:8]) ? 8'hFF : level_raw[7:0];
        sum       = {1'b0, acc} + {1'b0, level};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= 8'd0;
            audio_pwm <= 1'b0;
        end else begin
            acc       <= sum[7:0];
            audio_pwm <= sum[8];
        end
    end

endmodule
